// File: rtl/rgb_fade_sequencer_if.sv
// rtl/rgb_fade_sequencer_if.sv - control, table-load and color-output signals of the RGB fade sequencer
interface rgb_fade_sequencer_if;
   logic        start;
   logic        stop;
   logic        load_we;
   logic [1:0]  load_addr;
   logic [23:0] load_color;
   logic [1:0]  invert_cfg;
   logic [23:0] color;
   logic [1:0]  invert;
   logic        busy;
   logic        color_reached;

   modport master (
      output start, stop, load_we, load_addr, load_color, invert_cfg,
      input  color, invert, busy, color_reached
   );

   modport slave (
      input  start, stop, load_we, load_addr, load_color, invert_cfg,
      output color, invert, busy, color_reached
   );
endinterface

// File: rtl/rgb_fade_sequencer.sv
// rtl/rgb_fade_sequencer.sv - steps an RGB duty value through a 4-entry color table, fading then holding each entry
// Define RGB_FADE_GAMMA_EN to add a squared-gamma output stage (one extra cycle on color and invert).
module rgb_fade_sequencer #(
   parameter int unsigned STEP_DIV   = 1024,
   parameter int unsigned HOLD_STEPS = 256
) (
   input  logic             clk_i,
   input  logic             reset_i,
   rgb_fade_sequencer_if.slave bus
);
   localparam int unsigned DIV_W  = $clog2(STEP_DIV);
   localparam int unsigned HOLD_W = $clog2(HOLD_STEPS + 1);

   typedef enum logic [1:0] {IDLE, FADE, HOLD} state_t;

   state_t            state_q;
   logic [23:0]       table_q [4];
   logic [23:0]       cur_q;
   logic [23:0]       cur_d;
   logic [23:0]       target_q;
   logic [1:0]        index_q;
   logic [1:0]        index_d;
   logic [DIV_W-1:0]  div_q;
   logic [HOLD_W-1:0] hold_q;
   logic              busy_q;
   logic              reached_q;
   logic [23:0]       color_q;
   logic [1:0]        invert_q;
   logic              tick;

   function automatic logic [7:0] step_ch(input logic [7:0] c, input logic [7:0] t);
      if (c < t)      return c + 8'd1;
      else if (c > t) return c - 8'd1;
      else            return c;
   endfunction

   assign tick    = (state_q != IDLE) && (div_q == DIV_W'(STEP_DIV - 1));
   assign index_d = index_q + 2'd1;
   assign cur_d   = {step_ch(cur_q[23:16], target_q[23:16]),
                     step_ch(cur_q[15:8],  target_q[15:8]),
                     step_ch(cur_q[7:0],   target_q[7:0])};

   // Table is written in any state; target only samples it on entry load.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < 4; i++) table_q[i] <= '0;
      end else if (bus.load_we) begin
         table_q[bus.load_addr] <= bus.load_color;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         cur_q     <= '0;
         target_q  <= '0;
         index_q   <= '0;
         div_q     <= '0;
         hold_q    <= '0;
         busy_q    <= 1'b0;
         reached_q <= 1'b0;
      end else begin
         reached_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start && !bus.stop) begin
                  state_q  <= FADE;
                  index_q  <= 2'd0;
                  target_q <= table_q[0];
                  div_q    <= '0;
                  hold_q   <= '0;
                  busy_q   <= 1'b1;
               end
            end
            FADE: begin
               if (bus.stop) begin
                  state_q <= IDLE;
                  div_q   <= '0;
                  busy_q  <= 1'b0;
               end else if (cur_q == target_q) begin
                  state_q   <= HOLD;
                  reached_q <= 1'b1;
                  div_q     <= '0;
                  hold_q    <= '0;
               end else if (tick) begin
                  cur_q <= cur_d;
                  div_q <= '0;
               end else begin
                  div_q <= div_q + 1'b1;
               end
            end
            HOLD: begin
               if (bus.stop) begin
                  state_q <= IDLE;
                  div_q   <= '0;
                  busy_q  <= 1'b0;
               end else if (tick) begin
                  div_q <= '0;
                  if (hold_q == HOLD_W'(HOLD_STEPS - 1)) begin
                     state_q  <= FADE;
                     hold_q   <= '0;
                     index_q  <= index_d;
                     target_q <= table_q[index_d];
                  end else begin
                     hold_q <= hold_q + 1'b1;
                  end
               end else begin
                  div_q <= div_q + 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

`ifdef RGB_FADE_GAMMA_EN
   logic [23:0] pipe_q;
   logic [1:0]  inv_pipe_q;

   function automatic logic [7:0] gamma(input logic [7:0] c);
      logic [15:0] sq;
      sq = {8'd0, c} * {8'd0, c};
      return sq[15:8];
   endfunction

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         pipe_q     <= '0;
         inv_pipe_q <= '0;
         color_q    <= '0;
         invert_q   <= '0;
      end else begin
         pipe_q     <= cur_q;
         inv_pipe_q <= bus.invert_cfg;
         color_q    <= {gamma(pipe_q[23:16]), gamma(pipe_q[15:8]), gamma(pipe_q[7:0])};
         invert_q   <= inv_pipe_q;
      end
   end
`else
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         color_q  <= '0;
         invert_q <= '0;
      end else begin
         color_q  <= cur_q;
         invert_q <= bus.invert_cfg;
      end
   end
`endif

   assign bus.color         = color_q;
   assign bus.invert        = invert_q;
   assign bus.busy          = busy_q;
   assign bus.color_reached = reached_q;
endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// tb/tb_rgb_fade_sequencer.sv - directed-vector bench for rgb_fade_sequencer (STEP_DIV=4, HOLD_STEPS=2)
module tb_rgb_fade_sequencer;
   localparam int STEP_DIV   = 4;
   localparam int HOLD_STEPS = 2;
`ifdef RGB_FADE_GAMMA_EN
   localparam int LAT = 2;
   localparam logic [23:0] SETTLED_FF8000 = 24'hFE4000;
`else
   localparam int LAT = 1;
   localparam logic [23:0] SETTLED_FF8000 = 24'hFF8000;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   rgb_fade_sequencer_if bus ();

   rgb_fade_sequencer #(.STEP_DIV(STEP_DIV), .HOLD_STEPS(HOLD_STEPS)) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   logic        mon_en = 1'b0;
   logic        mon_bad = 1'b0;
   logic [23:0] mon_prev = '0;

   function automatic logic [7:0] g8(input logic [7:0] c);
`ifdef RGB_FADE_GAMMA_EN
      logic [15:0] sq;
      sq = {8'd0, c} * {8'd0, c};
      return sq[15:8];
`else
      return c;
`endif
   endfunction

   function automatic logic [23:0] g24(input logic [23:0] c);
      return {g8(c[23:16]), g8(c[15:8]), g8(c[7:0])};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load(input logic [1:0] a, input logic [23:0] c);
      bus.load_we    = 1'b1;
      bus.load_addr  = a;
      bus.load_color = c;
      cyc(1);
      bus.load_we    = 1'b0;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      cyc(1);
      bus.start = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc(2);
      reset = 1'b0;
      cyc(1);
   endtask

   task automatic wait_reached(input string tag, input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound && !ok; i++) begin
         cyc(1);
         if (bus.color_reached) ok = 1'b1;
      end
      if (!ok) check(tag, 32'd0, 32'd1);
   endtask

   // Per-channel step bound over the 0x00..0x0A test palette.
   always @(negedge clk) begin
      if (mon_en) begin
         for (int ch = 0; ch < 3; ch++) begin
            int a, b;
            a = int'(bus.color[ch*8 +: 8]);
            b = int'(mon_prev[ch*8 +: 8]);
            if (a > 10 || a - b > 1 || b - a > 1) mon_bad = 1'b1;
         end
         mon_prev = bus.color;
      end
   end

   initial begin
      logic [23:0] tgt [5];
      bit ok;
      int m;
      logic [7:0] er;

      bus.start = 1'b0; bus.stop = 1'b0; bus.load_we = 1'b0;
      bus.load_addr = '0; bus.load_color = '0; bus.invert_cfg = 2'b00;

      // Reset state
      cyc(2);
      check("rst_color", {8'd0, bus.color}, 32'h0);
      check("rst_invert", {30'd0, bus.invert}, 32'h0);
      check("rst_busy", {31'd0, bus.busy}, 32'h0);
      check("rst_reached", {31'd0, bus.color_reached}, 32'h0);
      reset = 1'b0;
      cyc(1);

      // Single-entry fade, cycle exact; active-entry rewrite mid-fade must not retarget
      load(2'd0, 24'h0A0000);
      pulse_start();
      for (int n = 1; n <= 45; n++) begin
         cyc(1);
         bus.load_we = 1'b0;
         m  = n - LAT;
         er = (m < 0) ? 8'd0 : ((m / 4) > 10 ? 8'd10 : 8'(m / 4));
         check($sformatf("fade1_color_n%0d", n), {8'd0, bus.color}, {8'd0, g8(er), 16'h0});
         check($sformatf("fade1_busy_n%0d", n), {31'd0, bus.busy}, 32'd1);
         check($sformatf("fade1_reached_n%0d", n), {31'd0, bus.color_reached}, {31'd0, n == 41});
         if (n == 20) begin
            bus.load_we = 1'b1; bus.load_addr = 2'd0; bus.load_color = 24'hFF0000;
         end
      end

      // Four-entry cycle with wrap; start during a fade is ignored
      do_reset();
      tgt[0] = 24'h0A0000; tgt[1] = 24'h000A00; tgt[2] = 24'h00000A;
      tgt[3] = 24'h0A0A0A; tgt[4] = 24'h0A0000;
      for (int k = 0; k < 4; k++) load(2'(k), tgt[k]);
      bus.invert_cfg = 2'b10;
      mon_prev = bus.color;
      mon_en = 1'b1;
      pulse_start();
      for (int k = 0; k < 5; k++) begin
         wait_reached($sformatf("cycle_timeout_k%0d", k), 300, ok);
         if (ok) begin
            cyc(1);
            check($sformatf("cycle_color_k%0d", k), {8'd0, bus.color}, {8'd0, g24(tgt[k])});
            if (k == 0) begin
               check("invert_follow", {30'd0, bus.invert}, 32'h2);
               cyc(10);
               pulse_start();
               check("start_in_fade_busy", {31'd0, bus.busy}, 32'd1);
            end
         end
      end
      mon_en = 1'b0;
      check("no_overshoot", {31'd0, mon_bad}, 32'd0);

      // Reset mid-HOLD: outputs clear immediately, table reads back zero
      cyc(2);
      #2 reset = 1'b1;
      #1;
      check("async_rst_color", {8'd0, bus.color}, 32'h0);
      check("async_rst_invert", {30'd0, bus.invert}, 32'h0);
      check("async_rst_busy", {31'd0, bus.busy}, 32'h0);
      check("async_rst_reached", {31'd0, bus.color_reached}, 32'h0);
      cyc(2);
      reset = 1'b0;
      cyc(1);
      pulse_start();
      wait_reached("zero_table_timeout", 10, ok);
      if (ok) begin
         cyc(1);
         check("zero_table_color", {8'd0, bus.color}, 32'h0);
         check("zero_table_busy", {31'd0, bus.busy}, 32'd1);
      end

      // Stop at R=5 freezes color; restart reloads entry 0
      do_reset();
      load(2'd0, 24'h0A0000);
      pulse_start();
      cyc(21);
      bus.stop = 1'b1;
      cyc(1);
      bus.stop = 1'b0;
      check("stop_busy", {31'd0, bus.busy}, 32'd0);
      cyc(LAT + 3);
      check("stop_color", {8'd0, bus.color}, {8'd0, g24(24'h050000)});
      cyc(20);
      check("stop_color_hold", {8'd0, bus.color}, {8'd0, g24(24'h050000)});
      check("stop_busy_hold", {31'd0, bus.busy}, 32'd0);
      load(2'd0, 24'h020000);
      pulse_start();
      wait_reached("restart_timeout", 100, ok);
      if (ok) begin
         cyc(1);
         check("restart_color", {8'd0, bus.color}, {8'd0, g24(24'h020000)});
      end

      // Start and stop together from IDLE: stop wins
      bus.stop = 1'b1;
      cyc(1);
      bus.stop = 1'b0;
      cyc(1);
      check("stop_from_hold_busy", {31'd0, bus.busy}, 32'd0);
      bus.start = 1'b1; bus.stop = 1'b1;
      cyc(1);
      bus.start = 1'b0; bus.stop = 1'b0;
      cyc(5);
      check("start_stop_busy", {31'd0, bus.busy}, 32'd0);
      check("start_stop_color", {8'd0, bus.color}, {8'd0, g24(24'h020000)});

      // Long fade to FF8000, settled value with or without gamma
      do_reset();
      load(2'd0, 24'hFF8000);
      pulse_start();
      wait_reached("settle_timeout", 1200, ok);
      if (ok) begin
         cyc(1);
         check("settled_color", {8'd0, bus.color}, {8'd0, SETTLED_FF8000});
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
